// File: rtl/fc_dai_cmd_sequencer.sv
// ============================================================================
// Module   : fc_dai_cmd_sequencer
// Brief    : Requester-side DAI CSR sequencer for fuse read/write/zeroize.
//            Optional write readback verify: FC_DAI_SEQ_READBACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fc_dai_cmd_sequencer #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [63:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [2:0]        rsp_err_o,
    output logic [63:0]       rsp_rdata_o,
    output logic              rsp_timeout_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    output logic [2:0]        reg_sel_o,
    output logic [31:0]       reg_wdata_o,
    input  logic [31:0]       reg_rdata_i,
    input  logic              dai_idle_i,
    input  logic [2:0]        dai_err_i,
    input  logic              escalate_i
);

    localparam int         c_cnt_w     = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_wr_adr = 4'd1;
    localparam logic [3:0] c_st_wr_d0  = 4'd2;
    localparam logic [3:0] c_st_wr_d1  = 4'd3;
    localparam logic [3:0] c_st_wr_cmd = 4'd4;
    localparam logic [3:0] c_st_wait   = 4'd5;
    localparam logic [3:0] c_st_rd_d0  = 4'd6;
    localparam logic [3:0] c_st_rd_d1  = 4'd7;
    localparam logic [3:0] c_st_resp   = 4'd8;
    localparam logic [3:0] c_st_locked = 4'd9;
    localparam logic [1:0] c_op_rd     = 2'd0;
    localparam logic [1:0] c_op_wr     = 2'd1;
    localparam logic [1:0] c_op_rsv    = 2'd3;

    logic [3:0]         r_state;
    logic [1:0]         r_op;
    logic [63:0]        r_wdata;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [2:0]         r_rsp_err;
    logic [63:0]        r_rsp_rdata;
    logic               r_rsp_timeout;
    logic               r_reg_we;
    logic               r_reg_re;
    logic [2:0]         r_reg_sel;
    logic [31:0]        r_reg_wdata;
    logic               w_rb;
    logic               w_accept;
    logic               w_inflight;
    logic               w_respond;
    logic [31:0]        w_cmd;

`ifdef FC_DAI_SEQ_READBACK_EN
    localparam logic    c_rb_en = 1'b1;
    logic               r_rb;
    logic [ADDR_W-1:0]  r_addr;
    assign w_rb = r_rb;
`else
    localparam logic    c_rb_en = 1'b0;
    assign w_rb = 1'b0;
`endif

    assign w_accept   = req_valid_i & r_req_ready;
    assign w_inflight = (r_state == c_st_resp) ? ~rsp_ready_i
                                               : ((r_state != c_st_idle) | w_accept);
    // A clean write finishes at WAIT unless a readback pass still has to run
    assign w_respond  = (dai_err_i != 3'd0) | ((r_op == c_op_wr) & ~w_rb & ~c_rb_en);
    assign w_cmd      = (w_rb || r_op == c_op_rd) ? 32'h1 :
                        (r_op == c_op_wr)          ? 32'h2 : 32'h8;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= c_st_idle;
            r_op          <= 2'd0;
            r_wdata       <= 64'd0;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 3'd0;
            r_rsp_rdata   <= 64'd0;
            r_rsp_timeout <= 1'b0;
            r_reg_we      <= 1'b0;
            r_reg_re      <= 1'b0;
            r_reg_sel     <= 3'd0;
            r_reg_wdata   <= 32'd0;
`ifdef FC_DAI_SEQ_READBACK_EN
            r_rb          <= 1'b0;
            r_addr        <= '0;
`endif
        end else begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_reg_sel   <= 3'd0;
            r_reg_wdata <= 32'd0;
            if (escalate_i && r_state != c_st_locked) begin
                r_state <= c_st_locked;
                if (w_inflight) begin
                    r_rsp_valid   <= 1'b1;
                    r_rsp_err     <= 3'd7;
                    r_rsp_rdata   <= 64'd0;
                    r_rsp_timeout <= 1'b0;
                    r_req_ready   <= 1'b0;
                end else begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_accept) begin
                            r_op          <= req_op_i;
                            r_wdata       <= req_wdata_i;
                            r_cnt         <= '0;
                            r_req_ready   <= 1'b0;
                            r_rsp_err     <= 3'd0;
                            r_rsp_rdata   <= 64'd0;
                            r_rsp_timeout <= 1'b0;
`ifdef FC_DAI_SEQ_READBACK_EN
                            r_rb          <= 1'b0;
                            r_addr        <= req_addr_i;
`endif
                            if (req_op_i == c_op_rsv) begin
                                r_state     <= c_st_resp;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 3'd5;
                            end else begin
                                r_state     <= c_st_wr_adr;
                                r_reg_we    <= 1'b1;
                                r_reg_sel   <= 3'd0;
                                r_reg_wdata <= 32'(req_addr_i);
                            end
                        end else begin
                            r_req_ready <= 1'b1;
                        end
                    end
                    c_st_wr_adr: begin
                        r_reg_we <= 1'b1;
                        if (r_op == c_op_wr && !w_rb) begin
                            r_state     <= c_st_wr_d0;
                            r_reg_sel   <= 3'd1;
                            r_reg_wdata <= r_wdata[31:0];
                        end else begin
                            r_state     <= c_st_wr_cmd;
                            r_reg_sel   <= 3'd3;
                            r_reg_wdata <= w_cmd;
                        end
                    end
                    c_st_wr_d0: begin
                        r_state     <= c_st_wr_d1;
                        r_reg_we    <= 1'b1;
                        r_reg_sel   <= 3'd2;
                        r_reg_wdata <= r_wdata[63:32];
                    end
                    c_st_wr_d1: begin
                        r_state     <= c_st_wr_cmd;
                        r_reg_we    <= 1'b1;
                        r_reg_sel   <= 3'd3;
                        r_reg_wdata <= w_cmd;
                    end
                    c_st_wr_cmd: begin
                        r_state <= c_st_wait;
                        r_cnt   <= '0;
                    end
                    c_st_wait: begin
                        // First WAIT cycle is blanking: DAI idle may still be stale
                        if (r_cnt != '0 && dai_idle_i) begin
                            if (w_respond) begin
                                r_state     <= c_st_resp;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= dai_err_i;
                            end else if (r_op == c_op_wr && !w_rb) begin
`ifdef FC_DAI_SEQ_READBACK_EN
                                r_rb        <= 1'b1;
                                r_reg_wdata <= 32'(r_addr);
`endif
                                r_state     <= c_st_wr_adr;
                                r_reg_we    <= 1'b1;
                                r_reg_sel   <= 3'd0;
                            end else begin
                                r_state   <= c_st_rd_d0;
                                r_reg_re  <= 1'b1;
                                r_reg_sel <= 3'd4;
                            end
                        end else if (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                            r_state       <= c_st_resp;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 3'd7;
                            r_rsp_timeout <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_st_rd_d0: begin
                        r_rsp_rdata[31:0] <= reg_rdata_i;
                        r_state           <= c_st_rd_d1;
                        r_reg_re          <= 1'b1;
                        r_reg_sel         <= 3'd5;
                    end
                    c_st_rd_d1: begin
                        r_state     <= c_st_resp;
                        r_rsp_valid <= 1'b1;
                        if (w_rb) begin
                            r_rsp_err   <= ({reg_rdata_i, r_rsp_rdata[31:0]} != r_wdata) ? 3'd6 : 3'd0;
                            r_rsp_rdata <= 64'd0;
                        end else begin
                            r_rsp_rdata[63:32] <= reg_rdata_i;
                        end
                    end
                    c_st_resp: begin
                        if (rsp_ready_i) begin
                            r_rsp_valid <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_state     <= c_st_idle;
                        end
                    end
                    c_st_locked: begin
                        if (r_rsp_valid) begin
                            if (rsp_ready_i) begin
                                r_rsp_valid <= 1'b0;
                                r_req_ready <= 1'b1;
                            end
                        end else if (w_accept) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 3'd7;
                            r_rsp_rdata   <= 64'd0;
                            r_rsp_timeout <= 1'b0;
                            r_req_ready   <= 1'b0;
                        end else begin
                            r_req_ready <= 1'b1;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_timeout_o = r_rsp_timeout;
    assign reg_we_o      = r_reg_we;
    assign reg_re_o      = r_reg_re;
    assign reg_sel_o     = r_reg_sel;
    assign reg_wdata_o   = r_reg_wdata;

endmodule

`default_nettype wire

// File: tb/tb_fc_dai_cmd_sequencer.sv
// ============================================================================
// Module   : tb_fc_dai_cmd_sequencer
// Brief    : Scoreboard bench for fc_dai_cmd_sequencer with a simple DAI model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fc_dai_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [2:0]  rsp_err;
    logic [63:0] rsp_rdata;
    logic        reg_we, reg_re;
    logic [2:0]  reg_sel;
    logic [31:0] reg_wdata, reg_rdata;
    logic        dai_idle, escalate;
    logic [2:0]  dai_err;
    logic [31:0] rd0, rd1;
    bit          locked_exp;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {logic [2:0] err; logic [63:0] rdata; logic to; int acc; int lat;} rsp_t;
    typedef struct {logic [2:0] sel; logic [31:0] data;} csr_t;
    rsp_t sbq[$];
    csr_t csrq[$];

    fc_dai_cmd_sequencer #(.ADDR_W(12), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err),
        .rsp_rdata_o(rsp_rdata), .rsp_timeout_o(rsp_timeout),
        .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_sel_o(reg_sel),
        .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata),
        .dai_idle_i(dai_idle), .dai_err_i(dai_err), .escalate_i(escalate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign reg_rdata = (reg_sel == 3'd4) ? rd0 : (reg_sel == 3'd5) ? rd1 : 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic csr(input logic [2:0] sel, input logic [31:0] data);
        csr_t c;
        c.sel = sel; c.data = data;
        csrq.push_back(c);
    endtask

    // Response monitor and CSR-traffic monitor
    always @(negedge clk) begin : mon
        rsp_t e;
        csr_t c;
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) flag("rsp_unexpected");
                else begin
                    e = sbq.pop_front();
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (reg_we) begin
                if (locked_exp) flag("csr_write_locked");
                else if (csrq.size() == 0) flag("csr_unexpected");
                else begin
                    c = csrq.pop_front();
                    chk("csr_sel", 64'(reg_sel), 64'(c.sel));
                    chk("csr_wdata", 64'(reg_wdata), 64'(c.data));
                end
            end
            if (reg_re && locked_exp) flag("csr_read_locked");
            if (reg_we && reg_re) flag("strobe_overlap");
        end
    end

    task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                         input bit want, input logic [2:0] err, input logic [63:0] rdata,
                         input logic to, input int lat);
        int n = 0;
        rsp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) flag("req_ready_timeout");
        else if (want) begin
            e.err = err; e.rdata = rdata; e.to = to; e.acc = cyc; e.lat = lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || csrq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || csrq.size() != 0) flag("drain_timeout");
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        chk({tag, "_reg_we"}, 64'(reg_we), 64'd0);
        chk({tag, "_reg_re"}, 64'(reg_re), 64'd0);
        chk({tag, "_reg_sel"}, 64'(reg_sel), 64'd0);
        chk({tag, "_reg_wdata"}, 64'(reg_wdata), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_wr;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 12'd0; req_wdata = 64'd0;
        rsp_ready = 1'b1; dai_idle = 1'b1; dai_err = 3'd0; escalate = 1'b0;
        rd0 = 32'd0; rd1 = 32'd0; locked_exp = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Write with clean completion
        csr(3'd0, 32'h40); csr(3'd1, 32'h0123_4567); csr(3'd2, 32'hDEAD_BEEF); csr(3'd3, 32'h2);
`ifdef FC_DAI_SEQ_READBACK_EN
        csr(3'd0, 32'h40); csr(3'd3, 32'h1);
        rd0 = 32'h0123_4567; rd1 = 32'hDEAD_BEEF;
        lat_wr = -1;
`else
        lat_wr = 7;
`endif
        issue(2'd1, 12'h040, 64'hDEAD_BEEF_0123_4567, 1'b1, 3'd0, 64'd0, 1'b0, lat_wr);
        drain();

        // Read
        rd0 = 32'h1111_1111; rd1 = 32'h2222_2222;
        csr(3'd0, 32'h100); csr(3'd3, 32'h1);
        issue(2'd0, 12'h100, 64'd0, 1'b1, 3'd0, 64'h2222_2222_1111_1111, 1'b0, 7);
        drain();

        // Zeroize
        rd0 = 32'hCAFE_F00D; rd1 = 32'h5A5A_5A5A;
        csr(3'd0, 32'h0F8); csr(3'd3, 32'h8);
        issue(2'd2, 12'h0F8, 64'hFFFF, 1'b1, 3'd0, 64'h5A5A_5A5A_CAFE_F00D, 1'b0, 7);
        drain();

        // Reserved op: no CSR traffic
        issue(2'd3, 12'h123, 64'd0, 1'b1, 3'd5, 64'd0, 1'b0, 1);
        drain();

        // Write rejected by DAI: no readback
        dai_err = 3'd5;
        csr(3'd0, 32'h44); csr(3'd1, 32'h89AB_CDEF); csr(3'd2, 32'h7654_3210); csr(3'd3, 32'h2);
        issue(2'd1, 12'h044, 64'h7654_3210_89AB_CDEF, 1'b1, 3'd5, 64'd0, 1'b0, 7);
        drain();

        // Read with DAI error skips data reads
        dai_err = 3'd6;
        csr(3'd0, 32'h108); csr(3'd3, 32'h1);
        issue(2'd0, 12'h108, 64'd0, 1'b1, 3'd6, 64'd0, 1'b0, 5);
        drain();
        dai_err = 3'd0;

        // Timeout after 16 WAIT cycles
        dai_idle = 1'b0;
        csr(3'd0, 32'h010); csr(3'd3, 32'h1);
        issue(2'd0, 12'h010, 64'd0, 1'b1, 3'd7, 64'd0, 1'b1, 19);
        drain();
        dai_idle = 1'b1;

`ifdef FC_DAI_SEQ_READBACK_EN
        // Readback mismatch
        rd0 = 32'd0; rd1 = 32'd0;
        csr(3'd0, 32'h020); csr(3'd1, 32'h1); csr(3'd2, 32'h0); csr(3'd3, 32'h2);
        csr(3'd0, 32'h020); csr(3'd3, 32'h1);
        issue(2'd1, 12'h020, 64'h1, 1'b1, 3'd6, 64'd0, 1'b0, -1);
        drain();
`endif

        // Reset mid-WAIT: no response must appear
        dai_idle = 1'b0;
        csr(3'd0, 32'h030); csr(3'd3, 32'h1);
        issue(2'd0, 12'h030, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0, -1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        dai_idle = 1'b1;
        repeat (12) @(negedge clk);
        drain();

        // Escalation during WAIT, then locked requests
        dai_idle = 1'b0;
        csr(3'd0, 32'h050); csr(3'd3, 32'h1);
        issue(2'd0, 12'h050, 64'd0, 1'b1, 3'd7, 64'd0, 1'b0, -1);
        repeat (3) @(negedge clk);
        escalate = 1'b1;
        @(negedge clk);
        escalate = 1'b0;
        locked_exp = 1'b1;
        drain();
        issue(2'd0, 12'h060, 64'd0, 1'b1, 3'd7, 64'd0, 1'b0, 1);
        dai_idle = 1'b1;
        issue(2'd1, 12'h068, 64'h55, 1'b1, 3'd7, 64'd0, 1'b0, 1);
        issue(2'd2, 12'h070, 64'd0, 1'b1, 3'd7, 64'd0, 1'b0, 1);
        drain();

        // Only reset leaves the locked state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        locked_exp = 1'b0;
        rd0 = 32'h0BAD_F00D; rd1 = 32'h1234_5678;
        csr(3'd0, 32'h078); csr(3'd3, 32'h1);
        issue(2'd0, 12'h078, 64'd0, 1'b1, 3'd0, 64'h1234_5678_0BAD_F00D, 1'b0, 7);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
